// File: rtl/cpu_hd_scoreboard_if.sv
// cpu_hd_scoreboard_if: decode/execute/commit hazard bus between the pipeline and the hazard unit
interface cpu_hd_scoreboard_if #(parameter int RID_W = 5);
  logic             dec_valid;
  logic [RID_W-1:0] dec_ra;
  logic [RID_W-1:0] dec_rb;
  logic [RID_W-1:0] dec_rd;
  logic             ra_use;
  logic             rb_use;
  logic             rd_use;
  logic             dec_is_mul;
  logic             dec_is_branch;
  logic             dec_is_jump;
  logic             flush;
  logic [RID_W-1:0] ex_rd;
  logic             ex_wb;
  logic             ex_mem_read;
  logic [RID_W-1:0] cm_rd;
  logic             cm_mem_read;
  logic             stall;
  logic [4:0]       stall_cause;
  modport master (
    output dec_valid, dec_ra, dec_rb, dec_rd, ra_use, rb_use, rd_use,
    output dec_is_mul, dec_is_branch, dec_is_jump, flush,
    output ex_rd, ex_wb, ex_mem_read, cm_rd, cm_mem_read,
    input  stall, stall_cause
  );
  modport slave (
    input  dec_valid, dec_ra, dec_rb, dec_rd, ra_use, rb_use, rd_use,
    input  dec_is_mul, dec_is_branch, dec_is_jump, flush,
    input  ex_rd, ex_wb, ex_mem_read, cm_rd, cm_mem_read,
    output stall, stall_cause
  );
endinterface

// File: rtl/cpu_hd_scoreboard.sv
// cpu_hd_scoreboard: decode hazard unit with per-register multiplier latency scoreboard
// Optional stall performance counter enabled by defining HDU_PERF_CNT_EN.
module cpu_hd_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int MUL_LATENCY = 5,
  parameter int PERF_W = 32,
  localparam int RID_W = $clog2(NUM_REGS),
  localparam int CNT_W = $clog2(MUL_LATENCY + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef HDU_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_stall_cnt,
`endif
  cpu_hd_scoreboard_if.slave hd
);
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [4:0] cause;
  logic stall;
  logic set;
  always_comb begin
    cause[0] = hd.ex_mem_read && ((hd.ra_use && hd.dec_ra == hd.ex_rd) || (hd.rb_use && hd.dec_rb == hd.ex_rd));
    cause[1] = hd.ex_wb && ((hd.dec_is_branch && (hd.dec_ra == hd.ex_rd || hd.dec_rb == hd.ex_rd)) ||
                            (hd.dec_is_jump && hd.dec_ra == hd.ex_rd));
    cause[2] = hd.cm_mem_read && ((hd.dec_is_branch && (hd.dec_ra == hd.cm_rd || hd.dec_rb == hd.cm_rd)) ||
                                  (hd.dec_is_jump && hd.dec_ra == hd.cm_rd));
    cause[3] = (hd.ra_use && cnt[hd.dec_ra] != '0) || (hd.rb_use && cnt[hd.dec_rb] != '0);
    cause[4] = hd.rd_use && cnt[hd.dec_rd] != '0;
  end
  // Outputs are forced low while reset is asserted, independent of decode inputs.
  assign hd.stall_cause = (reset_n && hd.dec_valid) ? cause : '0;
  assign stall = |hd.stall_cause;
  assign hd.stall = stall;
  assign set = hd.dec_valid && !stall && !hd.flush && hd.dec_is_mul && hd.rd_use;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '{default: '0};
    else
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= (set && hd.dec_rd == RID_W'(i)) ? CNT_W'(MUL_LATENCY) :
                  (cnt[i] != '0) ? cnt[i] - CNT_W'(1) : cnt[i];
`ifdef HDU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) perf_stall_cnt <= '0;
    else if (perf_clr) perf_stall_cnt <= '0;
    else if (stall && !hd.flush && !(&perf_stall_cnt)) perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
`endif
endmodule

// File: tb/tb_cpu_hd_scoreboard.sv
// tb_cpu_hd_scoreboard: directed and random checks of the hazard unit against a ready-time model
module tb_cpu_hd_scoreboard;
  localparam int L = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready [32];
  logic last_stall;
  int n;
  int k;
`ifdef HDU_PERF_CNT_EN
  logic perf_clr;
  logic [3:0] perf_stall_cnt;
  int pc = 0;
`endif
  always #5 clk = ~clk;
  cpu_hd_scoreboard_if #(.RID_W(5)) hd ();
  cpu_hd_scoreboard #(.NUM_REGS(32), .MUL_LATENCY(L), .PERF_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef HDU_PERF_CNT_EN
    .perf_clr(perf_clr),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .hd(hd)
  );
  // A register is busy while the current cycle precedes the cycle its mul result becomes forwardable.
  function automatic logic busy(input logic [4:0] r);
    return cyc < ready[r];
  endfunction
  function automatic logic [4:0] exp_cause();
    logic [4:0] c;
    if (!reset_n || !hd.dec_valid) return '0;
    c[0] = hd.ex_mem_read && ((hd.ra_use && hd.dec_ra == hd.ex_rd) || (hd.rb_use && hd.dec_rb == hd.ex_rd));
    c[1] = hd.ex_wb && ((hd.dec_is_branch && (hd.dec_ra == hd.ex_rd || hd.dec_rb == hd.ex_rd)) ||
                        (hd.dec_is_jump && hd.dec_ra == hd.ex_rd));
    c[2] = hd.cm_mem_read && ((hd.dec_is_branch && (hd.dec_ra == hd.cm_rd || hd.dec_rb == hd.cm_rd)) ||
                              (hd.dec_is_jump && hd.dec_ra == hd.cm_rd));
    c[3] = (hd.ra_use && busy(hd.dec_ra)) || (hd.rb_use && busy(hd.dec_rb));
    c[4] = hd.rd_use && busy(hd.dec_rd);
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < 32; i++) ready[i] = 0;
`ifdef HDU_PERF_CNT_EN
    pc = 0;
`endif
  endtask
  task automatic idle();
    hd.dec_valid = 0; hd.dec_ra = 0; hd.dec_rb = 0; hd.dec_rd = 0;
    hd.ra_use = 0; hd.rb_use = 0; hd.rd_use = 0;
    hd.dec_is_mul = 0; hd.dec_is_branch = 0; hd.dec_is_jump = 0; hd.flush = 0;
    hd.ex_rd = 0; hd.ex_wb = 0; hd.ex_mem_read = 0; hd.cm_rd = 0; hd.cm_mem_read = 0;
`ifdef HDU_PERF_CNT_EN
    perf_clr = 0;
`endif
  endtask
  task automatic dec(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                     input logic rau, input logic rbu, input logic rdu, input logic mul);
    hd.dec_valid = 1; hd.dec_ra = ra; hd.dec_rb = rb; hd.dec_rd = rd;
    hd.ra_use = rau; hd.rb_use = rbu; hd.rd_use = rdu; hd.dec_is_mul = mul;
  endtask
  task automatic step(input string tag);
    logic [4:0] e;
    #1;
    e = exp_cause();
    chk({tag, ".cause"}, 32'(hd.stall_cause), 32'(e));
    chk({tag, ".stall"}, 32'(hd.stall), 32'(|e));
`ifdef HDU_PERF_CNT_EN
    chk({tag, ".perf"}, 32'(perf_stall_cnt), 32'(pc));
`endif
    last_stall = hd.stall;
    @(posedge clk);
    if (hd.dec_valid && !(|e) && !hd.flush && hd.dec_is_mul && hd.rd_use) ready[hd.dec_rd] = cyc + 1 + L;
`ifdef HDU_PERF_CNT_EN
    pc = perf_clr ? 0 : ((|e) && !hd.flush && pc < 15) ? pc + 1 : pc;
`endif
    cyc++;
    #1;
  endtask
  task automatic count_stalls(input string tag);
    n = 0;
    k = 0;
    do begin
      step(tag);
      n += int'(last_stall);
      k++;
    end while (last_stall && k < 20);
  endtask
  initial begin
    clear_model();
    idle();
    dec(5, 5, 5, 1, 1, 1, 0);
    hd.ex_mem_read = 1; hd.ex_wb = 1; hd.ex_rd = 5;
    #1;
    chk("reset.stall", 32'(hd.stall), 0);
    chk("reset.cause", 32'(hd.stall_cause), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    idle();
    step("idle");
    // mul r3 then add r4,r3,r1: stalls exactly L cycles then issues
    dec(0, 0, 3, 0, 0, 1, 1); step("mul_r3");
    dec(3, 1, 4, 1, 1, 1, 0); count_stalls("raw");
    chk("raw.len", 32'(n), L);
    // load-use on ra, then bubble moves the load to commit
    idle(); dec(5, 0, 6, 1, 1, 1, 0);
    hd.ex_mem_read = 1; hd.ex_wb = 1; hd.ex_rd = 5; step("lu");
    chk("lu.stall", 32'(last_stall), 1);
    hd.ex_mem_read = 0; hd.ex_wb = 0; hd.cm_mem_read = 1; hd.cm_rd = 5; step("lu_done");
    chk("lu_done.stall", 32'(last_stall), 0);
    hd.ex_mem_read = 1; hd.ex_wb = 1; hd.cm_mem_read = 0; hd.ra_use = 0; hd.rb_use = 0; step("lu_nouse");
    chk("lu_nouse.stall", 32'(last_stall), 0);
    // WAW: mul r7 then addi r7 with unused rb=7
    idle(); dec(0, 0, 7, 0, 0, 1, 1); step("mul_r7");
    dec(1, 7, 7, 1, 0, 1, 0); count_stalls("waw");
    chk("waw.len", 32'(n), L);
    // beq r2,r9 with lw r9 in execute then commit
    idle(); dec(2, 9, 0, 1, 1, 0, 0); hd.dec_is_branch = 1;
    hd.ex_mem_read = 1; hd.ex_wb = 1; hd.ex_rd = 9; step("br1");
    hd.ex_mem_read = 0; hd.ex_wb = 0; hd.cm_mem_read = 1; hd.cm_rd = 9; step("br2");
    hd.cm_mem_read = 0; step("br3");
    // jump vs ALU result
    idle(); dec(4, 0, 1, 1, 0, 1, 0); hd.dec_is_jump = 1; hd.ex_wb = 1; hd.ex_rd = 4; step("jmp_alu");
    // flushed mul leaves no pending result
    idle(); dec(0, 0, 3, 0, 0, 1, 1); hd.flush = 1; step("mul_flush");
    hd.flush = 0; dec(3, 3, 8, 1, 1, 1, 0); step("flush_reader");
    chk("flush_reader.stall", 32'(last_stall), 0);
    // flush does not mask stall
    idle(); dec(5, 0, 6, 1, 0, 1, 0); hd.flush = 1; hd.ex_mem_read = 1; hd.ex_rd = 5; step("flush_stall");
    // reset in the middle of a countdown
    idle(); dec(0, 0, 3, 0, 0, 1, 1); step("mul_r3b");
    dec(3, 0, 4, 1, 0, 1, 0); step("cd1"); step("cd2");
    reset_n = 0;
    clear_model();
    #1;
    chk("async_rst.stall", 32'(hd.stall), 0);
    step("in_rst");
    reset_n = 1;
    step("after_rst");
    chk("after_rst.stall", 32'(last_stall), 0);
`ifdef HDU_PERF_CNT_EN
    idle(); perf_clr = 1; step("pclr0"); perf_clr = 0;
    dec(5, 0, 6, 1, 0, 1, 0); hd.ex_mem_read = 1; hd.ex_rd = 5;
    repeat (20) step("psat");
    chk("perf.sat", 32'(perf_stall_cnt), 15);
    perf_clr = 1; step("pclr"); perf_clr = 0;
    chk("perf.clr", 32'(perf_stall_cnt), 0);
`endif
    for (int i = 0; i < 400; i++) begin
      hd.dec_valid = $urandom_range(0, 3) != 0;
      hd.dec_ra = 5'($urandom_range(0, 7));
      hd.dec_rb = 5'($urandom_range(0, 7));
      hd.dec_rd = 5'($urandom_range(0, 7));
      hd.ra_use = 1'($urandom_range(0, 1));
      hd.rb_use = 1'($urandom_range(0, 1));
      hd.rd_use = 1'($urandom_range(0, 1));
      hd.dec_is_mul = $urandom_range(0, 2) == 0;
      hd.dec_is_branch = $urandom_range(0, 3) == 0;
      hd.dec_is_jump = $urandom_range(0, 3) == 0;
      hd.flush = $urandom_range(0, 7) == 0;
      hd.ex_rd = 5'($urandom_range(0, 7));
      hd.ex_wb = 1'($urandom_range(0, 1));
      hd.ex_mem_read = $urandom_range(0, 3) == 0;
      hd.cm_rd = 5'($urandom_range(0, 7));
      hd.cm_mem_read = $urandom_range(0, 3) == 0;
`ifdef HDU_PERF_CNT_EN
      perf_clr = $urandom_range(0, 15) == 0;
`endif
      step("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
